// File: rtl/timestamp_gen.sv
// timestamp_gen: counts rising edges of the divided tick clock in a free-running
// timestamp counter and captures the current timestamp into a small FIFO on
// event pulses. The FIFO head is offered downstream through valid/ready.
// Optional build macro: TIMESTAMP_GEN_SYNC_EN selects a two-flop synchronizer on
// tick_clk_i. Without it, tick_clk_i is registered once and must be synchronous
// to clk_i.
module timestamp_gen #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     tick_clk_i,
  input  logic                     clear_i,
  input  logic                     capture_i,
  output logic [WIDTH-1:0]         ts_o,
  output logic                     wrap_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // ---------------------------------------------------------------------------
  // Tick edge detection. Each stage carries a "holds a real sample" flag so
  // that a tick clock already high when reset releases is not seen as an edge.
  // ---------------------------------------------------------------------------
  logic sync_in;
  logic sync_in_v;
  logic sync_q, vsync_q;
  logic prev_q, vprev_q;
  logic tick;

`ifdef TIMESTAMP_GEN_SYNC_EN
  logic s1_q, vs1_q;

  // First synchronizer stage for the possibly asynchronous tick clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q  <= 1'b0;
      vs1_q <= 1'b0;
    end else begin
      s1_q  <= tick_clk_i;
      vs1_q <= 1'b1;
    end
  end

  assign sync_in   = s1_q;
  assign sync_in_v = vs1_q;
`else
  assign sync_in   = tick_clk_i;
  assign sync_in_v = 1'b1;
`endif

  // Synchronized tick level and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= 1'b0;
      vsync_q <= 1'b0;
      prev_q  <= 1'b0;
      vprev_q <= 1'b0;
    end else begin
      sync_q  <= sync_in;
      vsync_q <= sync_in_v;
      prev_q  <= sync_q;
      vprev_q <= vsync_q;
    end
  end

  assign tick = sync_q & ~prev_q & vprev_q;

  // ---------------------------------------------------------------------------
  // Timestamp counter and wrap pulse.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ts_q, ts_d;
  logic             wrap_q, wrap_d;

  // Next counter value: clear wins, otherwise count one per tick.
  always_comb begin
    ts_d   = ts_q;
    wrap_d = 1'b0;
    if (clear_i) begin
      ts_d = '0;
    end else if (tick) begin
      ts_d   = ts_q + WIDTH'(1);
      wrap_d = &ts_q;
    end
  end

  // Counter and wrap registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      wrap_q <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO. Pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    level;
  logic             empty, full;
  logic             pop, push, drop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));

  // A pop frees the slot a simultaneous push needs, so push is allowed when full.
  assign pop  = ready_i & ~empty & ~clear_i;
  assign push = capture_i & ~clear_i & (~full | pop);
  assign drop = capture_i & ~clear_i & full & ~pop;

  // Pointer and sticky-overflow next state; clear flushes everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | drop;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // FIFO pointer and overflow registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage entries; the timestamp present in the capture cycle is written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        mem_q[gi] <= '0;
      end else if (push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
        mem_q[gi] <= ts_q;
      end
    end
  end

  assign ts_o       = ts_q;
  assign wrap_o     = wrap_q;
  assign data_o     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o    = ~empty;
  assign overflow_o = ovf_q;
  assign level_o    = level;

endmodule

// File: tb/tb_timestamp_gen.sv
// Testbench for timestamp_gen: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_timestamp_gen;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int MODV  = 256;
`ifdef TIMESTAMP_GEN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             tick_clk_i;
  logic             clear_i;
  logic             capture_i;
  logic [WIDTH-1:0] ts_o;
  logic             wrap_o;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             overflow_o;
  logic [$clog2(DEPTH):0] level_o;

  timestamp_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .tick_clk_i (tick_clk_i),
    .clear_i    (clear_i),
    .capture_i  (capture_i),
    .ts_o       (ts_o),
    .wrap_o     (wrap_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ts = number of sampled rising edges of tick_clk_i, each taking effect LAT
  // edges after the edge that first sees it high; exp_q is the expected FIFO.
  int cyc = 0;
  int m_ts;
  bit m_wrap;
  bit m_ov;
  int exp_q[$];
  bit m_have_prev;
  bit m_last;
  bit sched[int];
  int inc;
  bit m_pop;
  bit m_room;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ts = 0; m_wrap = 0; m_ov = 0; exp_q.delete();
      m_have_prev = 0; m_last = 0; sched.delete();
    end else begin
      cyc++;
      inc = sched.exists(cyc) ? 1 : 0;
      if (inc != 0) sched.delete(cyc);
      if (m_have_prev && tick_clk_i && !m_last) sched[cyc + LAT] = 1'b1;
      m_last = tick_clk_i;
      m_have_prev = 1'b1;
      if (clear_i) begin
        m_ts = 0; m_wrap = 0; m_ov = 0; exp_q.delete();
      end else begin
        m_pop  = ready_i && (exp_q.size() > 0);
        m_room = (exp_q.size() < DEPTH) || m_pop;
        if (m_pop) void'(exp_q.pop_front());
        if (capture_i) begin
          if (m_room) exp_q.push_back(m_ts);
          else m_ov = 1'b1;
        end
        m_wrap = (inc != 0) && (m_ts == MODV - 1);
        m_ts = (m_ts + inc) % MODV;
      end
    end
  end

  // ---------------- monitor / scoreboard compare ----------------
  always @(negedge clk) begin
    chk("ts", ts_o, m_ts);
    chk("wrap", wrap_o, m_wrap);
    chk("valid", valid_o, exp_q.size() != 0);
    chk("level", level_o, exp_q.size());
    chk("overflow", overflow_o, m_ov);
    chk("data", data_o, (exp_q.size() != 0) ? exp_q[0] : 0);
  end

  // ---------------- stimulus ----------------
  int tick_half = 0;
  int ph = 0;

  task automatic cyc_drive(input bit cap, input bit rdy, input bit clr);
    @(posedge clk);
    #1;
    capture_i = cap;
    ready_i   = rdy;
    clear_i   = clr;
    if (tick_half > 0) begin
      ph++;
      if (ph >= tick_half) begin
        ph = 0;
        tick_clk_i = ~tick_clk_i;
      end
    end
  endtask

  task automatic hold_until(input int target, input bit rdy);
    int n = 0;
    while (m_ts != target && n < 3000) begin
      cyc_drive(1'b0, rdy, 1'b0);
      n++;
    end
    if (m_ts != target) begin
      checks++;
      fails++;
      $display("FAIL hold_until: ts reached %0d, required %0d", m_ts, target);
    end
  endtask

  int wraps;
  int first_val;
  int n;

  initial begin
    rst_n = 1'b0; tick_clk_i = 1'b1; clear_i = 0; capture_i = 0; ready_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Tick clock high out of reset must not count.
    repeat (10) cyc_drive(0, 0, 0);
    chk("high_out_of_reset_ts", ts_o, 0);

    // Five periods of 8 high / 8 low.
    tick_clk_i = 1'b0; ph = 0; tick_half = 8;
    repeat (80 + LAT + 3) cyc_drive(0, 0, 0);
    tick_half = 0;
    chk("five_ticks_ts", ts_o, 5);
    $display("five ticks: ts_o=%0d", ts_o);

    // Full wrap of the 8-bit counter.
    cyc_drive(0, 0, 1);
    tick_half = 2; ph = 0; tick_clk_i = 1'b0; wraps = 0;
    repeat (256 * 4 + 20) begin
      cyc_drive(0, 0, 0);
      if (wrap_o) begin
        wraps++;
        chk("wrap_ts_zero", ts_o, 0);
      end
    end
    chk("wrap_count", wraps, 1);
    $display("wrap: pulses=%0d", wraps);

    // Captures at 7, 9, 12 then drain.
    cyc_drive(0, 0, 1);
    hold_until(7, 0);  capture_i = 1'b1;
    hold_until(9, 0);  capture_i = 1'b1;
    hold_until(12, 0); capture_i = 1'b1;
    cyc_drive(0, 0, 0);
    tick_half = 0;
    chk("three_level", level_o, 3);
    chk("three_head", data_o, 7);
    cyc_drive(0, 1, 0); chk("pop0", data_o, 7);
    cyc_drive(0, 1, 0); chk("pop1", data_o, 9);
    cyc_drive(0, 1, 0); chk("pop2", data_o, 12);
    cyc_drive(0, 0, 0); chk("drained_valid", valid_o, 0);
    $display("drain: 7,9,12 popped");

    // Six captures into a 4-deep FIFO, then capture+pop while full.
    cyc_drive(0, 0, 1);
    tick_half = 2;
    first_val = -1;
    for (int i = 0; i < 6; i++) begin
      cyc_drive(1, 0, 0);
      if (first_val < 0) first_val = m_ts;
      repeat (3) cyc_drive(0, 0, 0);
    end
    tick_half = 0;
    chk("ovf_level", level_o, 4);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_head", data_o, first_val);
    cyc_drive(1, 1, 0);
    cyc_drive(0, 0, 0);
    chk("full_push_pop_level", level_o, 4);
    $display("overflow: level=%0d overflow=%0d", level_o, overflow_o);

    // Capture coincident with a tick at ts = 20.
    cyc_drive(0, 0, 1);
    tick_half = 2;
    n = 0;
    while (!(m_ts == 20 && sched.exists(cyc + 1)) && n < 2000) begin
      cyc_drive(0, 0, 0);
      n++;
    end
    if (n >= 2000) begin
      checks++; fails++;
      $display("FAIL coincide_wait: ts %0d, required 20 with pending tick", m_ts);
    end
    capture_i = 1'b1;
    cyc_drive(0, 0, 0);
    tick_half = 0;
    chk("coincide_ts", ts_o, 21);
    chk("coincide_data", data_o, 20);
    $display("coincide: ts_o=%0d data_o=%0d", ts_o, data_o);

    // Clear with level 3, overflow set, ts 99, capture in same cycle.
    cyc_drive(0, 0, 1);
    tick_half = 2;
    repeat (5) begin
      cyc_drive(1, 0, 0);
      cyc_drive(0, 0, 0);
    end
    cyc_drive(0, 1, 0);
    hold_until(99, 0);
    tick_half = 0;
    chk("pre_clear_level", level_o, 3);
    chk("pre_clear_ovf", overflow_o, 1);
    chk("pre_clear_ts", ts_o, 99);
    capture_i = 1'b1; clear_i = 1'b1;
    cyc_drive(0, 0, 0);
    chk("clear_ts", ts_o, 0);
    chk("clear_level", level_o, 0);
    chk("clear_valid", valid_o, 0);
    chk("clear_ovf", overflow_o, 0);
    $display("clear: ts_o=%0d level_o=%0d", ts_o, level_o);

    // Asynchronous reset in the middle of a capture.
    tick_half = 2;
    repeat (6) cyc_drive(1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ts", ts_o, 0);
    chk("rst_wrap", wrap_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_level", level_o, 0);
    $display("async reset: outputs zero");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic.
    tick_half = 2;
    repeat (3000) begin
      cyc_drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) tick_half = $urandom_range(2, 4);
    end
    cyc_drive(0, 0, 0);
    $display("random: done, ts_o=%0d level_o=%0d", ts_o, level_o);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/timestamp_gen.md
# timestamp_gen

Timestamp stage that sits directly downstream of the clock divider.
- Takes the divided slow clock as input, detects its rising edges in the system clock domain and counts them in a free-running timestamp counter.
- Captures the current timestamp into a small FIFO on event pulses from logger sources.
- Offers the captured values to the log formatter through a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32: timestamp counter width in bits (8..48).
- DEPTH, 4: capture FIFO depth in entries; must be a power of two, 2..16.

Ports:
- clk_i  in  1  system clock; all state is clocked on its rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- tick_clk_i  in  1  divided clock from the divider; one rising edge equals one timestamp unit.
- clear_i  in  1  synchronous clear pulse.
- capture_i  in  1  event pulse; one capture per high cycle.
- ts_o  out  WIDTH  current counter value.
- wrap_o  out  1  one-cycle pulse when the counter wraps.
- data_o  out  WIDTH  FIFO head timestamp.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts data_o; pop occurs when valid_o && ready_i.
- overflow_o  out  1  sticky flag: a capture was dropped.
- level_o  out  $clog2(DEPTH)+1  FIFO fill level.

## Operation
- Reset (rst_n_i low, asynchronous) forces all outputs and state to 0:
  - ts_o, wrap_o, data_o, valid_o, overflow_o and level_o are 0.
  - Synchronizer and edge registers are 0.
- Edge detect:
  - tick = sync_q & ~prev_q, so exactly one tick per tick_clk_i rising edge.
  - A tick_clk_i that is high out of reset does not produce a tick.
- Counter:
  - On tick, ts_o <= ts_o + 1, modulo 2^WIDTH.
  - On the all-ones -> 0 transition, wrap_o is high for exactly that one cycle (the cycle in which ts_o reads 0).
- Capture:
  - When capture_i is high, the value of ts_o present in that cycle is pushed, i.e. the pre-increment value if a tick coincides.
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH)+1 bits (the extra bit distinguishes full from empty).
  - data_o shows the head entry combinationally from the buffer.
  - data_o is 0 when empty.
  - Push and pop in the same cycle:
    - when not empty, both occur and level is unchanged;
    - when full, both occur (pop frees the slot) and nothing is dropped;
    - when empty, only the push occurs.
  - Capture while full without a pop: the value is dropped, the FIFO is unchanged and overflow_o is set.
  - overflow_o stays set until clear_i or reset.
- clear_i (highest priority):
  - Next cycle: ts_o = 0, FIFO flushed (level_o = 0, valid_o = 0), overflow_o = 0.
  - A capture_i or tick in the same cycle is discarded.
  - wrap_o is not asserted by clear.

## Timing
- With synchronizer, tick_clk_i is sampled high at clk_i edge k:
  - s1 at k, sync_q at k+1, tick valid during cycle k+1..k+2;
  - ts_o increments at edge k+2 (2-cycle latency after sampling).
- capture_i high at edge k:
  - entry written at k;
  - valid_o high and level_o updated after k, so usable in cycle k+1;
  - consumer may pop at edge k+1.
- Pop: data_o advances to the next entry in the cycle after the accepting edge.
- tick_clk_i high and low phases must each be ≥2 clk_i cycles with the synchronizer (≥1 without); the divider guarantees this for DIVISION ≥ 4.
- No combinational path from ready_i to valid_o.

## Configuration
- TIMESTAMP_GEN_SYNC_EN:
  - Defined: two-flop synchronizer (s1, sync_q) on tick_clk_i plus the prev_q edge register. tick_clk_i may be asynchronous to clk_i. Latency as above.
  - Undefined: tick_clk_i is registered once directly into sync_q and must be synchronous to clk_i. ts_o increments at edge k+1 after sampling at k; all other behaviour is identical.

## Test plan
- Reset, then 5 tick_clk_i periods of 8 clk_i high / 8 low -> ts_o = 5; increment edge 2 cycles (synchronizer defined) or 1 cycle (undefined) after the sampled rising edge; wrap_o stays 0.
- WIDTH=8, 256 ticks -> ts_o goes 255 -> 0, wrap_o high for exactly one cycle, ts_o = 0 in that cycle.
- capture_i at ts_o = 7, 9, 12 with ready_i held 0 -> level_o = 3, data_o = 7; then ready_i = 1 -> 7, 9, 12 popped on consecutive cycles, valid_o falls after the third.
- DEPTH=4, six captures with ready_i = 0 -> level_o = 4, overflow_o = 1, FIFO holds the first four values. A capture with simultaneous pop when full -> accepted, level_o stays 4.
- Capture in the same cycle as a tick at ts_o = 20 -> stored value 20, ts_o becomes 21.
- clear_i with level_o = 3, overflow_o = 1, ts_o = 99 and capture_i high in the same cycle -> next cycle ts_o = 0, level_o = 0, valid_o = 0, overflow_o = 0, nothing stored. rst_n_i pulsed low mid-capture -> all outputs 0 immediately.
